// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial add/subtract unit. A single full-adder slice processes one bit
//   per clock, LSB first. Operands are captured on a start pulse in IDLE. The
//   result appears with a one-cycle done pulse WIDTH+1 cycles after start.
//   Subtraction is performed as a + ~b + ~cin. For sub, cout = 1 means no
//   borrow.
//
//   Optional feature macro: SERIAL_ADDSUB_OVF_EN
//     When defined, the ovf output exists. It carries the signed overflow of
//     the last operation.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only in IDLE
//   sub    in   0 = add, 1 = subtract (captured with start)
//   a, b   in   WIDTH-bit operands (captured with start)
//   cin    in   carry-in / borrow-in (captured with start)
//   busy   out  high while the serial computation runs
//   done   out  one-cycle pulse when the result becomes valid
//   s      out  WIDTH-bit result, held until the next accepted start
//   cout   out  carry out of the MSB slice
//   ovf    out  signed overflow (SERIAL_ADDSUB_OVF_EN only)

module serial_addsub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  // Only WIDTH-1 sum bits need storing; the final bit joins them at DONE entry.
  logic [WIDTH-2:0] rr;
  logic [WIDTH-1:0] rr_nx;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_nx;
  logic             last;

  // Full-adder slice on the current LSBs plus the running carry.
  always_comb begin
    sum_bit  = ar[0] ^ br[0] ^ c;
    carry_nx = (ar[0] & br[0]) | (ar[0] & c) | (br[0] & c);
    rr_nx    = {sum_bit, rr};
    last     = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar   <= '0;
      br   <= '0;
      rr   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      s    <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ar  <= a;
            // Subtraction: invert b and the borrow so the slice only ever adds.
            br  <= b ^ {WIDTH{sub}};
            c   <= cin ^ sub;
            cnt <= '0;
          end
        end
        RUN: begin
          ar  <= {1'b0, ar[WIDTH-1:1]};
          br  <= {1'b0, br[WIDTH-1:1]};
          rr  <= rr_nx[WIDTH-1:1];
          c   <= carry_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            s    <= rr_nx;
            cout <= carry_nx;
`ifdef SERIAL_ADDSUB_OVF_EN
            // c is the carry into the MSB slice on this last RUN edge.
            ovf  <= c ^ carry_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
